simon_iter_core: RTL

- Parametrised Simon block-cipher encryption core; successor to the fixed Simon 32/64 pipeline.
- Supports all ten Simon 2n/mn variants via the parameters N and M.
- Computes one round per clock, with the round key expanded on the fly, so area is independent of round count.
- Sits between a host-side request source and a result sink; valid/ready handshake on both sides.

---
 rtl/simon_iter_core.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/simon_iter_core.sv
// -----------------------------------------------------------------------------
// simon_iter_core
// Iterative Simon 2n/mn block-cipher encryption core. One round is computed per
// clock and the round key is expanded on the fly, so one datapath serves every
// round count. Legal (N,M): (16,4) (24,3) (24,4) (32,3) (32,4) (48,2) (48,3)
// (64,2) (64,3) (64,4).
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_valid   request valid
//   in_ready   core can accept a request (IDLE only)
//   keytext    N*M-bit key, keytext[N-1:0] = k0, top word = k[M-1]
//   plaintext  2N-bit block {x,y}, x in the upper N bits
//   out_valid  ciphertext valid, held until out_ready
//   out_ready  sink accepts ciphertext
//   ciphertext 2N-bit result {x,y}; reads 0 whenever out_valid is low
//   busy       high while rounds are being computed
// -----------------------------------------------------------------------------
module simon_iter_core #(
   parameter int N = 16,
   parameter int M = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N*M-1:0]   keytext,
   input  logic [2*N-1:0]   plaintext,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*N-1:0]   ciphertext,
   output logic             busy
);

   // Standard Simon constant sequences; leftmost bit is sequence index 0.
   localparam logic [61:0] Z0 = 62'b11111010_00100101_01100001_11001101_11110100_01001010_11000011_100110;
   localparam logic [61:0] Z1 = 62'b10001110_11111001_00110000_10110101_00011101_11110010_01100001_011010;
   localparam logic [61:0] Z2 = 62'b10101111_01110000_00110100_10011000_10100001_00011111_10010110_110011;
   localparam logic [61:0] Z3 = 62'b11011011_10101100_01100101_11100000_01001000_10100111_00110100_001111;
   localparam logic [61:0] Z4 = 62'b11010001_11100110_10110110_00100000_01011100_00110010_10010011_101111;

   // Round count for a (n,m) pair; 0 marks an illegal pair.
   function automatic int rounds_f(input int n, input int m);
      case (n * 10 + m)
         164:     return 32'd32;
         243:     return 32'd36;
         244:     return 32'd36;
         323:     return 32'd42;
         324:     return 32'd44;
         482:     return 32'd52;
         483:     return 32'd54;
         642:     return 32'd68;
         643:     return 32'd69;
         644:     return 32'd72;
         default: return 32'd0;
      endcase
   endfunction

   // Which z sequence a (n,m) pair uses.
   function automatic logic [61:0] zseq_f(input int n, input int m);
      case (n * 10 + m)
         164:     return Z0;
         243:     return Z0;
         244:     return Z1;
         323:     return Z2;
         324:     return Z3;
         482:     return Z2;
         483:     return Z3;
         642:     return Z2;
         643:     return Z3;
         644:     return Z4;
         default: return Z0;
      endcase
   endfunction

   // Left rotate within N bits, 0 < s < N.
   function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int s);
      return (v << s) | (v >> (N - s));
   endfunction

   // Right rotate within N bits, 0 < s < N.
   function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int s);
      return (v >> s) | (v << (N - s));
   endfunction

   // Simon round nonlinearity.
   function automatic logic [N-1:0] simon_f(input logic [N-1:0] v);
      return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
   endfunction

   localparam int          T       = rounds_f(N, M);
   localparam logic [61:0] Z_SEQ   = zseq_f(N, M);
   localparam logic [6:0]  RC_LAST = 7'(T - 1);

   if (T == 0) begin : g_bad_pair
      $error("simon_iter_core: illegal (N,M) parameter pair");
   end

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t         state_r;
   logic [N-1:0]   x_r;
   logic [N-1:0]   y_r;
   logic [N-1:0]   kr_r [M];
   logic [6:0]     rc_r;
   logic [5:0]     zi_r;

   logic           z_bit_s;
   logic [N-1:0]   key_tmp_s;
   logic [N-1:0]   new_key_s;
   logic [N-1:0]   round_x_s;

   // Next round value and next key word from the current register contents.
   always_comb begin
      z_bit_s   = Z_SEQ[6'd61 - zi_r];
      key_tmp_s = ror(kr_r[M-1], 3);
      if (M == 4) begin
         key_tmp_s = key_tmp_s ^ kr_r[1];
      end else begin
         key_tmp_s = key_tmp_s;
      end
      key_tmp_s = key_tmp_s ^ ror(key_tmp_s, 1);
      // ~k0 ^ 3 is the same as c ^ k0 with c = 2^N - 4.
      new_key_s = ~kr_r[0] ^ key_tmp_s ^ {{(N-1){1'b0}}, z_bit_s} ^ {{(N-2){1'b0}}, 2'b11};
      round_x_s = y_r ^ simon_f(x_r) ^ kr_r[0];
   end

   // Control FSM, datapath registers and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         x_r        <= {N{1'b0}};
         y_r        <= {N{1'b0}};
         for (int j = 0; j < M; j++) begin
            kr_r[j] <= {N{1'b0}};
         end
         rc_r       <= 7'd0;
         zi_r       <= 6'd0;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
         ciphertext <= {(2*N){1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  x_r <= plaintext[2*N-1:N];
                  y_r <= plaintext[N-1:0];
                  for (int j = 0; j < M; j++) begin
                     kr_r[j] <= keytext[j*N +: N];
                  end
                  rc_r     <= 7'd0;
                  zi_r     <= 6'd0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state_r  <= RUN;
               end
            end
            RUN: begin
               x_r <= round_x_s;
               y_r <= x_r;
               for (int j = 0; j < M - 1; j++) begin
                  kr_r[j] <= kr_r[j+1];
               end
               kr_r[M-1] <= new_key_s;
               zi_r      <= (zi_r == 6'd61) ? 6'd0 : zi_r + 6'd1;
               rc_r      <= rc_r + 7'd1;
               if (rc_r == RC_LAST) begin
                  busy    <= 1'b0;
                  state_r <= DONE;
               end
            end
            DONE: begin
               // First DONE cycle publishes the result; it then holds until taken.
               if (!out_valid) begin
                  out_valid  <= 1'b1;
                  ciphertext <= {x_r, y_r};
               end else if (out_ready) begin
                  out_valid  <= 1'b0;
                  ciphertext <= {(2*N){1'b0}};
                  in_ready   <= 1'b1;
                  state_r    <= IDLE;
               end
            end
            default: begin
               state_r    <= IDLE;
               in_ready   <= 1'b1;
               out_valid  <= 1'b0;
               busy       <= 1'b0;
               ciphertext <= {(2*N){1'b0}};
            end
         endcase
      end
   end

endmodule
